axi_mm_patgen_top: RTL and testbench
====================================

# axi_mm_patgen_top

Pattern generator feeding the AXI-MM/AXIST data path of the GPIO full examples. Drives a count-limited or continuous burst of 64-bit-per-channel beats on a valid/ready interface. Mirrors every accepted beat into the pattern checker's expected-data FIFO so the far-end checker can compare received data against it. Sits on the leader transmit side, clocked by the checker's write clock `wrclk`.

## Interface
- AXI_CHNL_NUM, 1, number of 64-bit lanes per beat
- PRBS_SEED, 31'h1, base LFSR seed; lane n seeds with PRBS_SEED ^ n (never all-zero: zero forced to 1)
- wrclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- patgen_en  in  1  start request; rising edge (registered) starts a fixed-count run
- cntuspatt_en  in  1  level; rising edge starts a continuous run, falling edge ends it
- patgen_cnt  in  8  beats per fixed-count run (0 = no beats)
- pat_mode  in  1  0 = incrementing, 1 = PRBS-31 per lane; sampled at start
- chkr_fifo_full  in  1  checker expected-data FIFO full
- axist_tready  in  1  sink ready
- axist_valid  out  1  beat valid
- axist_data  out  64*AXI_CHNL_NUM  beat data
- patgen_din  out  64*AXI_CHNL_NUM  expected data to checker FIFO
- patgen_din_wr  out  1  checker FIFO write strobe
- patgen_busy  out  1  run in progress
- patgen_done  out  1  one-cycle pulse at run end
- patgen_beats  out  16  beats accepted in last/current run, saturating at 16'hFFFF

## Operation
- States: IDLE, RUN, DONE.
- IDLE: capture patgen_cnt, pat_mode, and reload lane LFSRs/counter. Go to RUN on a patgen_en rising edge or a cntuspatt_en rising edge; clear patgen_beats. Continuous mode takes priority when both edges occur together. patgen_cnt==0 in fixed mode goes straight to DONE.
- RUN, valid rules:
  - Assert axist_valid only when chkr_fifo_full==0.
  - Once asserted, hold axist_valid and axist_data stable until axist_tready. Full does not retract valid.
- Handshake (valid & tready):
  - Advance pattern.
  - Increment patgen_beats.
  - Next cycle: patgen_din = accepted data, patgen_din_wr = 1.
- Fixed mode: the handshake with beat index == cnt-1 is the last; go to DONE.
- Continuous mode: on a cntuspatt_en falling edge, stop raising new valids. A pending valid completes its handshake, then go to DONE.
- DONE: patgen_done = 1 for one cycle, then IDLE. patgen_busy = 1 in RUN and DONE.
- Incrementing pattern: lane n = {n[7:0], beat_index[55:0]}.
- PRBS pattern: lane n = 64 bits from that lane's PRBS-31 (x^31+x^28+1). The LFSR advances 64 steps per accepted beat (parallel update).
- Start edges arriving while in RUN or DONE are ignored.

## Timing
- Reset values: axist_valid 0, axist_data 0, patgen_din 0, patgen_din_wr 0, patgen_busy 0, patgen_done 0, patgen_beats 0, state IDLE, LFSRs = seeds.
- Edge detect adds 1 cycle. First axist_valid comes 2 cycles after the patgen_en input rises (given not full).
- With tready and !full held high, throughput is one beat per cycle.
- patgen_din_wr lags its axist handshake by exactly 1 cycle. Total patgen_din_wr pulses in a run = patgen_beats.
- patgen_done rises the cycle after the last handshake.
- rst mid-run: all outputs return to reset values next edge; the in-flight beat is dropped with no checker write.
- A chkr_fifo_full that rises while valid is already high does not block completion of that beat.

## Structure
- Shared package: PRBS-31 taps, state encoding, lane width constant 64.
- Sub-module `axi_mm_prbs31_lane`: one 31-bit LFSR with a 64-step parallel advance. Instantiated AXI_CHNL_NUM times.

## Test plan
- Fixed mode, patgen_cnt=8, pat_mode=0, tready=1 -> 8 beats with data 0..7 in lane 0; 8 patgen_din_wr pulses with matching data; patgen_beats=8; one patgen_done.
- tready toggled 1-0 randomly, pat_mode=1, cnt=20 -> valid/data stable while tready=0; the checker-side stream equals a reference PRBS-31 model.
- chkr_fifo_full high at start for 5 cycles, then low -> no valid during those cycles; first beat follows full deassert.
- Continuous mode: cntuspatt_en high 100 cycles then low with tready=0 at the fall -> the pending beat completes when tready returns; no further valids; patgen_done fires.
- rst asserted at beat 3 of a cnt=10 run -> next cycle valid 0, busy 0, beats 0; a new start produces data from beat 0.
- patgen_cnt=0 -> no valid, patgen_done pulse 2 cycles after patgen_en rises.

Source files
------------

// File: rtl/axi_mm_patgen_pkg.sv
// rtl/axi_mm_patgen_pkg.sv - shared constants, state encoding and seed helper for the pattern generator
package axi_mm_patgen_pkg;
    localparam int LANE_W      = 64;
    localparam int PRBS_W      = 31;
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;
    localparam int IDX_W       = 56;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } patgen_state_e;

    // An all-zero LFSR never leaves zero, so that seed is replaced by 1.
    function automatic logic [PRBS_W-1:0] lane_seed(input logic [PRBS_W-1:0] base, input int lane);
        logic [PRBS_W-1:0] s;
        s = base ^ PRBS_W'(lane);
        return (s == '0) ? PRBS_W'(1) : s;
    endfunction
endpackage

// File: rtl/axi_mm_patgen_if.sv
// rtl/axi_mm_patgen_if.sv - beat stream between pattern generator and sink
interface axi_mm_patgen_if #(parameter int AXI_CHNL_NUM = 1);
    logic                          axist_valid;
    logic                          axist_tready;
    logic [64*AXI_CHNL_NUM-1:0]    axist_data;

    modport master (output axist_valid, output axist_data, input axist_tready);
    modport slave  (input axist_valid, input axist_data, output axist_tready);
endinterface

// File: rtl/axi_mm_prbs31_lane.sv
// rtl/axi_mm_prbs31_lane.sv - one PRBS-31 lane producing 64 bits per beat with a 64-step parallel advance
module axi_mm_prbs31_lane
    import axi_mm_patgen_pkg::*;
#(
    parameter logic [PRBS_W-1:0] SEED = 31'h1
) (
    input  logic              wrclk,
    input  logic              rst,
    input  logic              use_seed_i,
    input  logic              adv_i,
    output logic [LANE_W-1:0] data_o
);
    logic [PRBS_W-1:0] lfsr_q;
    logic [PRBS_W-1:0] lfsr_d;
    logic [PRBS_W-1:0] cur;
    logic [PRBS_W-1:0] nxt;

    assign cur = use_seed_i ? SEED : lfsr_q;

    // Bit k of the word is the (k+1)-th bit shifted in from the current state.
    always_comb begin
        logic [PRBS_W-1:0] walk;
        logic              fb;
        walk   = cur;
        data_o = '0;
        for (int k = 0; k < LANE_W; k++) begin
            fb        = walk[PRBS_TAP_HI] ^ walk[PRBS_TAP_LO];
            data_o[k] = fb;
            walk      = {walk[PRBS_W-2:0], fb};
        end
        nxt = walk;
    end

    assign lfsr_d = adv_i ? nxt : cur;

    always_ff @(posedge wrclk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/axi_mm_patgen_top.sv
// rtl/axi_mm_patgen_top.sv - count-limited or continuous pattern burst with checker FIFO mirror
module axi_mm_patgen_top
    import axi_mm_patgen_pkg::*;
#(
    parameter int          AXI_CHNL_NUM = 1,
    parameter logic [30:0] PRBS_SEED    = 31'h1
) (
    input  logic                        wrclk,
    input  logic                        rst,
    input  logic                        patgen_en,
    input  logic                        cntuspatt_en,
    input  logic [7:0]                  patgen_cnt,
    input  logic                        pat_mode,
    input  logic                        chkr_fifo_full,
    axi_mm_patgen_if.master             axist,
    output logic [64*AXI_CHNL_NUM-1:0]  patgen_din,
    output logic                        patgen_din_wr,
    output logic                        patgen_busy,
    output logic                        patgen_done,
    output logic [15:0]                 patgen_beats
);
    localparam int DW = LANE_W * AXI_CHNL_NUM;

    patgen_state_e    state_q, state_d;
    logic             en_q, cen_q, en_rise_q, cen_rise_q, cen_fall_q;
    logic             mode_q, mode_d, cont_q, cont_d, stop_q, stop_d;
    logic             valid_q, valid_d, din_wr_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] pres_q, pres_d, idx;
    logic [DW-1:0]    data_q, data_d, din_q, pat_data;
    logic [15:0]      beats_q, beats_d;
    logic             idle, hs, load, use_mode;

    assign idle     = (state_q == ST_IDLE);
    assign hs       = valid_q & axist.axist_tready;
    assign use_mode = idle ? pat_mode : mode_q;
    assign idx      = idle ? '0 : pres_q;

    // Lane sources always hold the next beat not yet presented; loading a beat advances them.
    for (genvar n = 0; n < AXI_CHNL_NUM; n++) begin : g_lane
        logic [LANE_W-1:0] lane_prbs;
        axi_mm_prbs31_lane #(.SEED(lane_seed(PRBS_SEED, n))) u_lane (
            .wrclk      (wrclk),
            .rst        (rst),
            .use_seed_i (idle),
            .adv_i      (load),
            .data_o     (lane_prbs)
        );
        assign pat_data[n*LANE_W +: LANE_W] = use_mode ? lane_prbs : {8'(n), idx};
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        valid_d = valid_q;
        data_d  = data_q;
        pres_d  = pres_q;
        beats_d = beats_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mode_d = pat_mode;
                cnt_d  = patgen_cnt;
                stop_d = 1'b0;
                pres_d = '0;
                if (cen_rise_q) begin
                    cont_d  = 1'b1;
                    beats_d = '0;
                    state_d = ST_RUN;
                    load    = !chkr_fifo_full;
                end else if (en_rise_q) begin
                    cont_d  = 1'b0;
                    beats_d = '0;
                    if (patgen_cnt == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        load    = !chkr_fifo_full;
                    end
                end
            end
            ST_RUN: begin
                stop_d = stop_q | (cont_q & cen_fall_q);
                if (hs && beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
                // A new beat may only be presented once nothing is pending.
                if (!valid_q || hs) begin
                    if (cont_q ? !stop_d : (pres_q < IDX_W'(cnt_q))) load = !chkr_fifo_full;
                    else                                             state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            valid_d = 1'b1;
            data_d  = pat_data;
            pres_d  = idx + IDX_W'(1);
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            cen_q      <= 1'b0;
            en_rise_q  <= 1'b0;
            cen_rise_q <= 1'b0;
            cen_fall_q <= 1'b0;
            mode_q     <= 1'b0;
            cont_q     <= 1'b0;
            stop_q     <= 1'b0;
            cnt_q      <= '0;
            pres_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            din_q      <= '0;
            din_wr_q   <= 1'b0;
            beats_q    <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= patgen_en;
            cen_q      <= cntuspatt_en;
            en_rise_q  <= patgen_en & ~en_q;
            cen_rise_q <= cntuspatt_en & ~cen_q;
            cen_fall_q <= ~cntuspatt_en & cen_q;
            mode_q     <= mode_d;
            cont_q     <= cont_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_d;
            pres_q     <= pres_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            din_wr_q   <= hs;
            beats_q    <= beats_d;
            if (hs) din_q <= data_q;
        end
    end

    assign axist.axist_valid = valid_q;
    assign axist.axist_data  = data_q;
    assign patgen_din        = din_q;
    assign patgen_din_wr     = din_wr_q;
    assign patgen_busy       = (state_q != ST_IDLE);
    assign patgen_done       = (state_q == ST_DONE);
    assign patgen_beats      = beats_q;
endmodule

// File: tb/tb_axi_mm_patgen_top.sv
// tb/tb_axi_mm_patgen_top.sv - randomized self-checking bench for axi_mm_patgen_top
module tb_axi_mm_patgen_top;
    localparam int          NCH  = 2;
    localparam int          DW   = 64 * NCH;
    localparam logic [30:0] SEED = 31'h1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          patgen_en = 1'b0;
    logic          cntuspatt_en = 1'b0;
    logic [7:0]    patgen_cnt = 8'd0;
    logic          pat_mode = 1'b0;
    logic          full = 1'b0;
    logic [DW-1:0] patgen_din;
    logic          patgen_din_wr, patgen_busy, patgen_done;
    logic [15:0]   patgen_beats;

    logic rdy_rand = 1'b0, rdy_val = 1'b1, full_rand = 1'b0, full_val = 1'b0;
    int   cyc = 0;
    int   n_checks = 0, n_errors = 0;

    axi_mm_patgen_if #(.AXI_CHNL_NUM(NCH)) bus ();

    axi_mm_patgen_top #(.AXI_CHNL_NUM(NCH), .PRBS_SEED(SEED)) dut (
        .wrclk          (clk),
        .rst            (rst),
        .patgen_en      (patgen_en),
        .cntuspatt_en   (cntuspatt_en),
        .patgen_cnt     (patgen_cnt),
        .pat_mode       (pat_mode),
        .chkr_fifo_full (full),
        .axist          (bus),
        .patgen_din     (patgen_din),
        .patgen_din_wr  (patgen_din_wr),
        .patgen_busy    (patgen_busy),
        .patgen_done    (patgen_done),
        .patgen_beats   (patgen_beats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.axist_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.axist_tready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_val;
            full = full_rand ? ($urandom_range(3, 0) == 0) : full_val;
        end
    end

    // Sink-side observer: accepted beats, checker writes, protocol violations.
    logic [DW-1:0] acc[$];
    logic [DW-1:0] wr[$];
    int            done_cnt = 0, mon_err = 0;
    logic          pv = 1'b0, pr = 1'b0, pf = 1'b0, phs = 1'b0, prst = 1'b1;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        logic hs_s;
        hs_s = bus.axist_valid & bus.axist_tready & !rst;
        if (!rst && !prst) begin
            if (pv && !pr && !(bus.axist_valid && bus.axist_data == pd)) mon_err++;
            if (bus.axist_valid && !pv && pf) mon_err++;
            if (patgen_din_wr != phs) mon_err++;
            if (phs && patgen_din != pd) mon_err++;
        end
        if (hs_s) acc.push_back(bus.axist_data);
        if (patgen_din_wr) wr.push_back(patgen_din);
        if (patgen_done) done_cnt++;
        pv = bus.axist_valid; pr = bus.axist_tready; pd = bus.axist_data;
        pf = full; phs = hs_s; prst = rst;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference PRBS-31 as a bit sequence: x[t] = x[t-31] ^ x[t-28], seed bits oldest first.
    function automatic logic [63:0] prbs_word(input logic [30:0] sd, input int b);
        bit          x[$];
        logic [63:0] w;
        for (int j = 0; j < 31; j++) x.push_back(sd[30-j]);
        for (int t = 31; t < 31 + 64 * (b + 1); t++) x.push_back(x[t-31] ^ x[t-28]);
        for (int k = 0; k < 64; k++) w[k] = x[31 + 64 * b + k];
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input logic mode, input int b);
        logic [DW-1:0] r;
        logic [30:0]   sd;
        for (int n = 0; n < NCH; n++) begin
            sd = SEED ^ 31'(n);
            if (sd == 31'd0) sd = 31'd1;
            r[n*64 +: 64] = mode ? prbs_word(sd, b) : {8'(n), 56'(b)};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fixed(input logic [7:0] n, input logic mode, output int s);
        step();
        patgen_cnt = n;
        pat_mode   = mode;
        patgen_en  = 1'b1;
        s          = cyc;
    endtask

    task automatic wait_done(input int budget, input int s, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (patgen_done) begin
                lat = cyc - s;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", DW'(0), DW'(1));
    endtask

    task automatic check_run(input string tag, input int ab, input int wb, input int db,
                             input int n, input logic mode);
        chk({tag, " beats"}, DW'(patgen_beats), DW'(n));
        chk({tag, " n_acc"}, DW'(acc.size() - ab), DW'(n));
        chk({tag, " n_wr"}, DW'(wr.size() - wb), DW'(n));
        chk({tag, " done_pulses"}, DW'(done_cnt - db), DW'(1));
        chk({tag, " protocol"}, DW'(mon_err), DW'(0));
        for (int i = 0; i < n && ab + i < acc.size(); i++) chk({tag, " beat"}, acc[ab+i], exp_beat(mode, i));
        for (int i = 0; i < n && wb + i < wr.size(); i++) chk({tag, " din"}, wr[wb+i], exp_beat(mode, i));
    endtask

    initial begin
        int s, lat, ab, wb, db, n0, vhits;
        repeat (3) step();
        @(negedge clk);
        chk("rst valid", DW'(bus.axist_valid), DW'(0));
        chk("rst data", bus.axist_data, DW'(0));
        chk("rst din", patgen_din, DW'(0));
        chk("rst din_wr", DW'(patgen_din_wr), DW'(0));
        chk("rst busy", DW'(patgen_busy), DW'(0));
        chk("rst done", DW'(patgen_done), DW'(0));
        chk("rst beats", DW'(patgen_beats), DW'(0));
        step();
        rst = 1'b0;
        repeat (2) step();

        // fixed 8 beats, incrementing, full throughput
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        start_fixed(8'd8, 1'b0, s);
        repeat (2) @(negedge clk);
        chk("fix8 valid_at_1", DW'(bus.axist_valid), DW'(0));
        @(negedge clk);
        chk("fix8 valid_at_2", DW'(bus.axist_valid), DW'(1));
        chk("fix8 busy", DW'(patgen_busy), DW'(1));
        wait_done(50, s, lat);
        chk("fix8 done_latency", DW'(lat), DW'(10));
        step(); patgen_en = 1'b0; repeat (3) step();
        check_run("fix8", ab, wb, db, 8, 1'b0);

        // PRBS with random backpressure and random full
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        rdy_rand = 1'b1; full_rand = 1'b1;
        start_fixed(8'd20, 1'b1, s);
        wait_done(600, s, lat);
        step(); patgen_en = 1'b0; rdy_rand = 1'b0; full_rand = 1'b0; repeat (3) step();
        check_run("prbs20", ab, wb, db, 20, 1'b1);

        // checker FIFO full at start
        full_val = 1'b1; repeat (2) step();
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        start_fixed(8'd4, 1'b0, s);
        vhits = 0;
        repeat (5) begin @(negedge clk); if (bus.axist_valid) vhits++; end
        step(); full_val = 1'b0;
        @(negedge clk);
        chk("full no_valid", DW'(vhits + int'(bus.axist_valid)), DW'(0));
        @(negedge clk);
        chk("full first_valid", DW'(bus.axist_valid), DW'(1));
        wait_done(50, s, lat);
        step(); patgen_en = 1'b0; repeat (3) step();
        check_run("full4", ab, wb, db, 4, 1'b0);

        // continuous run, stopped while a beat is pending
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        step(); pat_mode = 1'b1; cntuspatt_en = 1'b1; s = cyc;
        repeat (100) step();
        rdy_val = 1'b0; repeat (3) step();
        cntuspatt_en = 1'b0; repeat (5) step();
        @(negedge clk);
        chk("cont pending_valid", DW'(bus.axist_valid), DW'(1));
        n0 = acc.size();
        rdy_val = 1'b1;
        wait_done(50, s, lat);
        vhits = 0;
        repeat (5) begin @(negedge clk); if (bus.axist_valid) vhits++; end
        chk("cont no_more_valid", DW'(vhits), DW'(0));
        chk("cont pending_done", DW'(acc.size()), DW'(n0 + 1));
        check_run("cont", ab, wb, db, n0 + 1 - ab, 1'b1);

        // reset in the middle of a fixed run
        ab = acc.size();
        start_fixed(8'd10, 1'b0, s);
        for (int i = 0; i < 50 && acc.size() - ab < 3; i++) @(negedge clk);
        chk("rst_mid reached", DW'(acc.size() - ab >= 3), DW'(1));
        step(); rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid valid", DW'(bus.axist_valid), DW'(0));
        chk("rst_mid busy", DW'(patgen_busy), DW'(0));
        chk("rst_mid beats", DW'(patgen_beats), DW'(0));
        chk("rst_mid din_wr", DW'(patgen_din_wr), DW'(0));
        step(); rst = 1'b0; patgen_en = 1'b0; repeat (3) step();
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        start_fixed(8'd4, 1'b0, s);
        wait_done(50, s, lat);
        step(); patgen_en = 1'b0; repeat (3) step();
        check_run("after_rst", ab, wb, db, 4, 1'b0);

        // zero-length fixed run
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        start_fixed(8'd0, 1'b0, s);
        wait_done(20, s, lat);
        chk("cnt0 done_latency", DW'(lat), DW'(2));
        step(); patgen_en = 1'b0; repeat (3) step();
        check_run("cnt0", ab, wb, db, 0, 1'b0);

        // simultaneous start edges: continuous wins over a 3-beat fixed run
        ab = acc.size(); wb = wr.size(); db = done_cnt;
        step(); patgen_cnt = 8'd3; pat_mode = 1'b0; patgen_en = 1'b1; cntuspatt_en = 1'b1; s = cyc;
        repeat (20) step();
        cntuspatt_en = 1'b0;
        wait_done(50, s, lat);
        step(); patgen_en = 1'b0; repeat (3) step();
        chk("both cont_priority", DW'(acc.size() - ab > 3), DW'(1));
        check_run("both", ab, wb, db, acc.size() - ab, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
